// File: rtl/int_ctrl51_if.sv
// CPU-side request channel of the 8051 interrupt controller.
// master = controller (drives irq/vector/irq_src), slave = instruction sequencer.
interface int_ctrl51_if;
   logic        irq;
   logic [15:0] vector;
   logic [2:0]  irq_src;
   logic        ack;
   logic        reti;

   modport master (output irq, vector, irq_src, input ack, reti);
   modport slave  (input irq, vector, irq_src, output ack, reti);
endinterface

// File: rtl/int_ctrl51.sv
// 8051 interrupt controller: five sources, IE/IP gating, two nesting levels,
// one registered request at a time with vector, in-service tracking until RETI.
module int_ctrl51 #(
   parameter logic [15:0] VEC_BASE = 16'h0003,
   parameter int          VEC_STEP = 8
) (
   input  logic        CLK,
   input  logic        resetn,
   input  logic        int0_n,
   input  logic        int1_n,
   input  logic        it0,
   input  logic        it1,
   input  logic        tf0_set,
   input  logic        tf1_set,
   input  logic        ri,
   input  logic        ti,
   input  logic [7:0]  ie,
   input  logic [7:0]  ip,
   input  logic [3:0]  flag_clr,
   int_ctrl51_if.master cpu,
   output logic        ie0,
   output logic        tf0,
   output logic        ie1,
   output logic        tf1,
   output logic [1:0]  in_service
);

   typedef enum logic {IDLE, REQ} state_t;

   state_t      state;
   logic [2:0]  x0, x1;          // [1:0] synchronizer, [2] previous synced value
   logic        irq_r, lvl;
   logic [15:0] vec_r;
   logic [2:0]  src_r;
   logic [4:0]  pend, elig, hi, lo;
   logic [2:0]  win;
   logic        win_v, take;
   logic [3:0]  clr;
   logic [1:0]  ins_nxt;
   logic        unused_bits;

   assign unused_bits = ^{ie[6:5], ip[7:5]};

   assign take = (state == REQ) & cpu.ack;
   assign clr  = flag_clr | ({4{take}} & (4'b0001 << src_r));

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         x0 <= 3'b111;
         x1 <= 3'b111;
      end else begin
         x0 <= {x0[1:0], int0_n};
         x1 <= {x1[1:0], int1_n};
      end
   end

   // Set beats a same-cycle clear for both edge and timer flags.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         ie0 <= 1'b0;
         ie1 <= 1'b0;
         tf0 <= 1'b0;
         tf1 <= 1'b0;
      end else begin
         if (!it0)                   ie0 <= ~x0[1];
         else if (x0[2] & ~x0[1])    ie0 <= 1'b1;
         else if (clr[0])            ie0 <= 1'b0;
         if (!it1)                   ie1 <= ~x1[1];
         else if (x1[2] & ~x1[1])    ie1 <= 1'b1;
         else if (clr[2])            ie1 <= 1'b0;
         if (tf0_set)                tf0 <= 1'b1;
         else if (clr[1])            tf0 <= 1'b0;
         if (tf1_set)                tf1 <= 1'b1;
         else if (clr[3])            tf1 <= 1'b0;
      end
   end

   assign pend = {ri | ti, tf1, ie1, tf0, ie0} & ie[4:0] & {5{ie[7]}};
   assign elig = in_service[1] ? 5'b0 : (in_service[0] ? (pend & ip[4:0]) : pend);
   assign hi   = elig & ip[4:0];
   assign lo   = elig & ~ip[4:0];

   // Descending scans so the lowest index wins; high level overrides low.
   always_comb begin
      win   = 3'd0;
      win_v = |elig;
      for (int i = 4; i >= 0; i--)
         if (lo[i]) win = 3'(i);
      for (int i = 4; i >= 0; i--)
         if (hi[i]) win = 3'(i);
   end

   // RETI retires the innermost level before a same-cycle ack opens a new one.
   always_comb begin
      ins_nxt = in_service;
      if (cpu.reti) begin
         if (ins_nxt[1]) ins_nxt[1] = 1'b0;
         else            ins_nxt[0] = 1'b0;
      end
      if (take) ins_nxt[lvl] = 1'b1;
   end

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         irq_r      <= 1'b0;
         vec_r      <= 16'h0000;
         src_r      <= 3'd0;
         lvl        <= 1'b0;
         in_service <= 2'b00;
      end else begin
         in_service <= ins_nxt;
         case (state)
            IDLE: if (win_v) begin
               src_r <= win;
               lvl   <= ip[win];
               vec_r <= VEC_BASE + 16'(win) * 16'(VEC_STEP);
               irq_r <= 1'b1;
               state <= REQ;
            end
            REQ: if (cpu.ack || !pend[src_r]) begin
               irq_r <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cpu.irq     = irq_r;
   assign cpu.vector  = vec_r;
   assign cpu.irq_src = src_r;

endmodule
